pull_fifo_responder: RTL and testbench
======================================

// Module: pull_fifo_responder
// PURPOSE
//  Responder (producer) end of the pull interface: accepts a push stream (in_data/in_nd)
//  and presents read_full/read_data/read_delete to a downstream pull reader.
//  Circular FIFO with one-cycle overflow/underflow error strobes and a fill count.
//  Sits between any nd-stream source and a consumer that pulls words on demand.
// PARAMETERS
//  WDTH       32  data word width in bits
//  DEPTH      16  FIFO capacity in words; must be a power of 2, >= 2
//  LOG_DEPTH  4   log2(DEPTH); pointer width
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  reset        in   1            asynchronous, active-high reset
//  in_data      in   WDTH         word to store, valid when in_nd=1
//  in_nd        in   1            write strobe: one word per cycle high
//  read_delete  in   1            pop strobe: discard head word at this edge
//  read_full    out  1            head word is valid on read_data
//  read_data    out  WDTH         head word; stable while read_full=1 and no pop
//  write_error  out  1            in_nd while FIFO full (word dropped)
//  read_error   out  1            read_delete while FIFO empty
//  fill_count   out  LOG_DEPTH+1  words currently stored, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, fill_count=0, read_full=0,
//    read_data=0, write_error=0, read_error=0. Reset mid-operation discards all words.
//  - Storage: DEPTH x WDTH array; pointers LOG_DEPTH bits, wrap DEPTH-1 -> 0 silently.
//  - Write: in_nd=1 and (not full or pop this cycle) -> store at wr_ptr, wr_ptr+1.
//  - Pop: read_delete=1 and fill_count>0 -> rd_ptr+1.
//  - Latency: word written at edge N is on read_data with read_full=1 after edge N
//    (if FIFO was empty); pop at edge N exposes the next word after edge N.
//  - read_full = (fill_count != 0), registered; read_data registered from array[rd_ptr].
//  - fill_count: +1 write only, -1 pop only, unchanged on both or neither.
//  - Simultaneous cases:
//    full + in_nd + read_delete: pop and write both succeed, no write_error.
//    empty + in_nd + read_delete: read_error=1, write succeeds, fill_count -> 1.
//    full + in_nd, no pop: word dropped, write_error=1 for one cycle, state unchanged.
//    empty + read_delete, no write: read_error=1 one cycle, state unchanged.
//  - Error strobes registered: high the cycle after the offending edge, for one cycle
//    per offending cycle (back-to-back offences hold them high).
//  - Reader contract: read_delete only with read_full=1; otherwise read_error reports it.
// CONFIGURATION
//  PULL_FIFO_STICKY_ERR_EN defined: write_error/read_error are sticky once set,
//    cleared only by reset; FIFO continues operating normally after an error.
//  Not defined: errors are one-cycle strobes as described in BEHAVIOUR.
// TESTING
//  1 Reset, write 0x11,0x22,0x33 on consecutive cycles -> read_full=1 one cycle after
//    first write, read_data=0x11, fill_count=3; pop x3 -> 0x22,0x33, then read_full=0.
//  2 Write DEPTH words (0..15), then 17th (0xDEAD) -> write_error=1 one cycle,
//    fill_count=16; drain -> 0..15 in order, 0xDEAD never appears.
//  3 Empty FIFO, read_delete=1 -> read_error=1 one cycle, fill_count=0, read_full=0.
//  4 Full FIFO, in_nd=1 (0xBEEF) with read_delete=1 -> no errors, fill_count=16,
//    read_data=1; after draining, 0xBEEF is last word out (wrap-around check).
//  5 Stream 100 words with continuous pop while read_full -> output order 0..99,
//    no errors, fill_count <= 2 throughout; assert reset mid-stream -> all outputs 0
//    immediately, next write appears as first word.
//  6 With PULL_FIFO_STICKY_ERR_EN: overflow once -> write_error stays 1 across 50
//    cycles of normal traffic until reset; without macro it drops after one cycle.

Source files
------------

// File: rtl/pull_fifo_responder.sv
// Producer end of a pull interface: circular FIFO fed by an nd-stream and drained on demand.
// Optional PULL_FIFO_STICKY_ERR_EN makes the error flags sticky until reset.
module pull_fifo_responder #(
  parameter int WDTH      = 32,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  input  logic                 read_delete,
  output logic                 read_full,
  output logic [WDTH-1:0]      read_data,
  output logic                 write_error,
  output logic                 read_error,
  output logic [LOG_DEPTH:0]   fill_count
);

  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH+1)'(DEPTH);

  logic [WDTH-1:0]      mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [LOG_DEPTH:0]   remain;
  logic                 read_full_q, read_full_d;
  logic [WDTH-1:0]      read_data_q, read_data_d;
  logic                 write_error_q, write_error_d;
  logic                 read_error_q, read_error_d;
  logic                 full, empty, pop_ok, wr_ok, werr, rerr;

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    pop_ok   = read_delete && !empty;
    // A pop on a full FIFO frees the slot the incoming word lands in.
    wr_ok    = in_nd && (!full || read_delete);
    werr     = in_nd && full && !read_delete;
    rerr     = read_delete && empty;

    wr_ptr_d = wr_ok  ? wr_ptr_q + LOG_DEPTH'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + LOG_DEPTH'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!wr_ok && pop_ok) count_d = count_q - 1'b1;

    // When nothing older survives this edge, the new head is the word being written.
    remain = pop_ok ? count_q - 1'b1 : count_q;
    if (remain == '0 && wr_ok) read_data_d = in_data;
    else                       read_data_d = mem_q[rd_ptr_d];

    read_full_d = (count_d != '0);

`ifdef PULL_FIFO_STICKY_ERR_EN
    write_error_d = write_error_q | werr;
    read_error_d  = read_error_q  | rerr;
`else
    write_error_d = werr;
    read_error_d  = rerr;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      read_full_q   <= 1'b0;
      read_data_q   <= '0;
      write_error_q <= 1'b0;
      read_error_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      read_full_q   <= read_full_d;
      read_data_q   <= read_data_d;
      write_error_q <= write_error_d;
      read_error_q  <= read_error_d;
    end
  end

  assign read_full   = read_full_q;
  assign read_data   = read_data_q;
  assign write_error = write_error_q;
  assign read_error  = read_error_q;
  assign fill_count  = count_q;

endmodule

// File: tb/tb_pull_fifo_responder.sv
// Directed bench for pull_fifo_responder: fill/drain, overflow, underflow, wrap, streaming, reset.
module tb_pull_fifo_responder;

  localparam int WDTH = 32;
  localparam int DEPTH = 16;
  localparam int LOG_DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [WDTH-1:0]     in_data = '0;
  logic                in_nd = 1'b0;
  logic                read_delete = 1'b0;
  logic                read_full;
  logic [WDTH-1:0]     read_data;
  logic                write_error;
  logic                read_error;
  logic [LOG_DEPTH:0]  fill_count;

  int n_cmp = 0;
  int n_err = 0;

  pull_fifo_responder #(.WDTH(WDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_nd(in_nd),
    .read_delete(read_delete), .read_full(read_full), .read_data(read_data),
    .write_error(write_error), .read_error(read_error), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_nd = 1'b0; read_delete = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic fill_seq(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_nd = 1'b1; in_data = WDTH'(base + i);
      step();
    end
    in_nd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (read_full !== 1'b0 || read_data !== '0 || fill_count !== '0 ||
        write_error !== 1'b0 || read_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset: full=%b data=%h fc=%0d werr=%b rerr=%b, required all 0",
               read_full, read_data, fill_count, write_error, read_error);
    end
    $display("reset: full=%b data=%h fc=%0d", read_full, read_data, fill_count);
  endtask

  task automatic test_basic();
    logic [WDTH-1:0] exp_words [3];
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
    in_nd = 1'b1; in_data = 32'h11;
    step();
    n_cmp++;
    if (read_full !== 1'b1 || read_data !== 32'h11 || fill_count !== 5'd1) begin
      n_err++;
      $display("FAIL basic_first: full=%b data=%h fc=%0d, required 1/11/1", read_full, read_data, fill_count);
    end
    in_data = 32'h22; step();
    in_data = 32'h33; step();
    in_nd = 1'b0;
    n_cmp++;
    if (read_data !== 32'h11 || fill_count !== 5'd3) begin
      n_err++;
      $display("FAIL basic_fill: data=%h fc=%0d, required 11/3", read_data, fill_count);
    end
    for (int i = 0; i < 3; i++) begin
      read_delete = 1'b1;
      step();
      n_cmp++;
      if (i < 2) begin
        if (read_full !== 1'b1 || read_data !== exp_words[i+1] || fill_count !== 5'(2 - i)) begin
          n_err++;
          $display("FAIL basic_pop%0d: full=%b data=%h fc=%0d, required 1/%h/%0d",
                   i, read_full, read_data, fill_count, exp_words[i+1], 2 - i);
        end
      end else if (read_full !== 1'b0 || fill_count !== 5'd0 || read_error !== 1'b0) begin
        n_err++;
        $display("FAIL basic_empty: full=%b fc=%0d rerr=%b, required 0/0/0", read_full, fill_count, read_error);
      end
      $display("basic pop %0d: data=%h fc=%0d", i, read_data, fill_count);
    end
    read_delete = 1'b0;
  endtask

  task automatic test_overflow();
    fill_seq(0, DEPTH);
    in_nd = 1'b1; in_data = 32'hDEAD;
    step();
    in_nd = 1'b0;
    n_cmp++;
    if (write_error !== 1'b1 || fill_count !== 5'd16 || read_data !== 32'h0) begin
      n_err++;
      $display("FAIL overflow_strobe: werr=%b fc=%0d data=%h, required 1/16/0", write_error, fill_count, read_data);
    end
    step();
    n_cmp++;
    if (write_error !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear: werr=%b, required 0", write_error);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (read_full !== 1'b1 || read_data !== WDTH'(i)) begin
        n_err++;
        $display("FAIL overflow_drain%0d: full=%b data=%h, required 1/%h", i, read_full, read_data, i);
      end
      read_delete = 1'b1;
      step();
    end
    read_delete = 1'b0;
    n_cmp++;
    if (read_full !== 1'b0 || fill_count !== 5'd0) begin
      n_err++;
      $display("FAIL overflow_empty: full=%b fc=%0d data=%h, required 0/0", read_full, fill_count, read_data);
    end
    $display("overflow: drained %0d words", DEPTH);
  endtask

  task automatic test_underflow();
    read_delete = 1'b1;
    step();
    read_delete = 1'b0;
    n_cmp++;
    if (read_error !== 1'b1 || fill_count !== 5'd0 || read_full !== 1'b0) begin
      n_err++;
      $display("FAIL underflow_strobe: rerr=%b fc=%0d full=%b, required 1/0/0", read_error, fill_count, read_full);
    end
    step();
    n_cmp++;
    if (read_error !== 1'b0) begin
      n_err++;
      $display("FAIL underflow_clear: rerr=%b, required 0", read_error);
    end
    $display("underflow: rerr cleared=%b", ~read_error);
  endtask

  task automatic test_full_pop_write();
    logic [WDTH-1:0] exp;
    fill_seq(0, DEPTH);
    in_nd = 1'b1; in_data = 32'hBEEF; read_delete = 1'b1;
    step();
    in_nd = 1'b0; read_delete = 1'b0;
    n_cmp++;
    if (write_error !== 1'b0 || read_error !== 1'b0 || fill_count !== 5'd16 || read_data !== 32'h1) begin
      n_err++;
      $display("FAIL full_popwrite: werr=%b rerr=%b fc=%0d data=%h, required 0/0/16/1",
               write_error, read_error, fill_count, read_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == DEPTH - 1) ? 32'hBEEF : WDTH'(i + 1);
      n_cmp++;
      if (read_data !== exp) begin
        n_err++;
        $display("FAIL wrap_drain%0d: data=%h, required %h", i, read_data, exp);
      end
      read_delete = 1'b1;
      step();
    end
    read_delete = 1'b0;
    n_cmp++;
    if (read_full !== 1'b0 || fill_count !== 5'd0) begin
      n_err++;
      $display("FAIL wrap_empty: full=%b fc=%0d, required 0/0", read_full, fill_count);
    end
    $display("full pop+write: BEEF drained last");
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int bad = 0;
    int max_fc = 0;
    int errs = 0;
    for (int k = 0; k < 100 + 8; k++) begin
      if (read_full === 1'b1) begin
        if (read_data !== WDTH'(got)) bad++;
        got++;
        read_delete = 1'b1;
      end else begin
        read_delete = 1'b0;
      end
      in_nd = (k < 100); in_data = WDTH'(k);
      step();
      if (int'(fill_count) > max_fc) max_fc = int'(fill_count);
      if (write_error !== 1'b0 || read_error !== 1'b0) errs++;
    end
    in_nd = 1'b0; read_delete = 1'b0;
    n_cmp++;
    if (got !== 100 || bad !== 0) begin
      n_err++;
      $display("FAIL stream_order: received=%0d out_of_order=%0d, required 100/0", got, bad);
    end
    n_cmp++;
    if (max_fc > 2 || errs !== 0) begin
      n_err++;
      $display("FAIL stream_level: max_fc=%0d error_cycles=%0d, required <=2/0", max_fc, errs);
    end
    $display("stream: received=%0d max_fc=%0d", got, max_fc);

    fill_seq(32'h50, 3);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (read_full !== 1'b0 || read_data !== '0 || fill_count !== '0 ||
        write_error !== 1'b0 || read_error !== 1'b0) begin
      n_err++;
      $display("FAIL midreset: full=%b data=%h fc=%0d werr=%b rerr=%b, required all 0",
               read_full, read_data, fill_count, write_error, read_error);
    end
    step();
    reset = 1'b0;
    in_nd = 1'b1; in_data = 32'h77;
    step();
    in_nd = 1'b0;
    n_cmp++;
    if (read_data !== 32'h77 || fill_count !== 5'd1 || read_full !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: data=%h fc=%0d full=%b, required 77/1/1", read_data, fill_count, read_full);
    end
    read_delete = 1'b1;
    step();
    read_delete = 1'b0;
    $display("midreset: first word after reset ok");
  endtask

  task automatic test_sticky();
    logic exp_werr;
    int bad = 0;
    fill_seq(0, DEPTH);
    in_nd = 1'b1; in_data = 32'hDEAD;
    step();
    n_cmp++;
    if (write_error !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_set: werr=%b, required 1", write_error);
    end
`ifdef PULL_FIFO_STICKY_ERR_EN
    exp_werr = 1'b1;
`else
    exp_werr = 1'b0;
`endif
    for (int i = 0; i < 50; i++) begin
      in_nd = 1'b1; in_data = WDTH'(i + 32'h100); read_delete = 1'b1;
      step();
      if (write_error !== exp_werr || fill_count !== 5'd16) bad++;
    end
    in_nd = 1'b0; read_delete = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL sticky_hold: bad_cycles=%0d werr=%b, required 0/%b", bad, write_error, exp_werr);
    end
    do_reset();
    n_cmp++;
    if (write_error !== 1'b0 || fill_count !== '0) begin
      n_err++;
      $display("FAIL sticky_reset: werr=%b fc=%0d, required 0/0", write_error, fill_count);
    end
    $display("error mode: werr after traffic expected %b", exp_werr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_full_pop_write();
    test_back_to_back();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
